e203_exu_fpu_fmis_arb: RTL and testbench
========================================

Name: e203_exu_fpu_fmis_arb

Overview:
- Shares the single FPU misc-move datapath (operand pass-through, combinational) between two requesters.
  - Requester 0: integer-to-FP moves (fmv.w.x), issued from the integer pipe.
  - Requester 1: FP-to-integer moves (fmv.x.w), issued from the FPU register-read stage.
- Round-robin arbitration; tags each accepted op with its destination info.
- Registers datapath results in a small result FIFO that drives the shared writeback port. This breaks the combinational path from requester to writeback.

Parameters:
- DEPTH, 2, result FIFO entries (power of two, >=2).
- ITAG_W, 2, instruction tag width.
- RDIDX_W, 5, destination register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_req  in  1  pipeline flush; discards buffered results
- r0_valid  in  1  requester 0 valid
- r0_ready  out  1  requester 0 accepted
- r0_rs1  in  32  requester 0 operand
- r0_rdidx  in  RDIDX_W  requester 0 destination index
- r0_itag  in  ITAG_W  requester 0 tag
- r1_valid  in  1  requester 1 valid
- r1_ready  out  1  requester 1 accepted
- r1_rs1  in  32  requester 1 operand
- r1_rdidx  in  RDIDX_W  requester 1 destination index
- r1_itag  in  ITAG_W  requester 1 tag
- mv_i_valid  out  1  datapath input valid
- mv_i_ready  in  1  datapath input ready
- mv_i_rs1  out  32  datapath operand
- mv_o_valid  in  1  datapath result valid
- mv_o_ready  out  1  datapath result ready
- mv_o_wdat  in  32  datapath result
- wbck_valid  out  1  writeback valid
- wbck_ready  in  1  writeback ready
- wbck_wdat  out  32  writeback data
- wbck_rdidx  out  RDIDX_W  writeback destination index
- wbck_rdfpu  out  1  1 = FP regfile (came from r0), 0 = integer regfile (came from r1)
- wbck_itag  out  ITAG_W  writeback tag

Behaviour:
- Reset (async, rst_n low):
  - FIFO count, read pointer and write pointer are 0.
  - Round-robin pointer is 0 (requester 0 favoured).
  - wbck_valid is 0. All wbck_* data outputs are 0.
- Arbitration (combinational, each cycle):
  - Defined signals: has_room = (count < DEPTH) or (wbck_valid and wbck_ready); blocked = flush_req or not has_room.
  - If blocked: no grant.
  - Else if exactly one requester is valid: it is granted.
  - Else if both are valid: the requester selected by the round-robin pointer is granted.
- Datapath drive:
  - mv_i_valid = any grant.
  - mv_i_rs1 = granted requester's rs1, else 0.
  - mv_o_ready = has_room and not flush_req.
- Acceptance:
  - rN_ready = grant_N and mv_i_ready.
  - On the cycle mv_o_valid and mv_o_ready, the FIFO pushes {mv_o_wdat, granted rdidx, granted itag, rdfpu}.
  - Requester side info is captured in the same cycle; no separate sideband queue.
- Round-robin pointer: after a push where both requesters were valid, it points to the non-granted requester. Otherwise it is unchanged.
- Writeback and timing:
  - wbck_valid = (count != 0). wbck_* fields come from the head entry.
  - Pop occurs on wbck_valid and wbck_ready.
  - Latency: accepted op appears on wbck_valid the next cycle at the earliest.
  - Throughput: 1 op/cycle when wbck_ready is held high.
- FIFO boundary rules:
  - Full (count == DEPTH) with no pop: no grant, both rN_ready are 0.
  - Full with pop in the same cycle: push allowed; count is unchanged.
  - Empty: wbck_valid is 0; a push makes it 1 next cycle. There is no same-cycle bypass.
  - Simultaneous push and pop: count is unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
- Flush:
  - In the flush cycle: count and both pointers go to 0, no grant, no push.
  - The round-robin pointer is kept.
  - Any pop in the flush cycle is ignored.
- Reset mid-operation: all state returns to reset values immediately; buffered results are lost.
- Holding rule: count never exceeds DEPTH, and a requester is never granted while its valid is low.

Test Plan:
- Single op: r0_valid=1, rs1=0x3F800000, rdidx=3, itag=1, wbck_ready=1 -> r0_ready=1 in cycle 0; next cycle wbck_valid=1, wdat=0x3F800000, rdidx=3, rdfpu=1, itag=1.
- Contention: both valid for 4 cycles, wbck_ready=1 -> grants alternate r0,r1,r0,r1; wbck_rdfpu sequence 1,0,1,0.
- Backpressure: wbck_ready=0, r1 issues 3 ops -> first 2 accepted, third sees r1_ready=0 with count=2; raise wbck_ready -> third accepted in the same cycle as the pop, with count still 2.
- Datapath stall: mv_i_ready=0 with r0_valid=1 -> r0_ready=0, no push, round-robin pointer unchanged.
- Flush: 2 entries buffered, flush_req=1 for one cycle while r0_valid=1 -> no grant; next cycle wbck_valid=0 and a new op is accepted normally.
- Async reset mid-stream: drop rst_n with 1 entry buffered -> wbck_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/e203_exu_fpu_fmis_arb.sv
// Round-robin arbiter that shares the FPU misc-move datapath between the integer
// pipe (fmv.w.x) and the FPU read stage (fmv.x.w); results are queued in a small FIFO for writeback.
module e203_exu_fpu_fmis_arb #(
  parameter int DEPTH   = 2,
  parameter int ITAG_W  = 2,
  parameter int RDIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_req,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [31:0]        r0_rs1,
  input  logic [RDIDX_W-1:0] r0_rdidx,
  input  logic [ITAG_W-1:0]  r0_itag,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [31:0]        r1_rs1,
  input  logic [RDIDX_W-1:0] r1_rdidx,
  input  logic [ITAG_W-1:0]  r1_itag,
  output logic               mv_i_valid,
  input  logic               mv_i_ready,
  output logic [31:0]        mv_i_rs1,
  input  logic               mv_o_valid,
  output logic               mv_o_ready,
  input  logic [31:0]        mv_o_wdat,
  output logic               wbck_valid,
  input  logic               wbck_ready,
  output logic [31:0]        wbck_wdat,
  output logic [RDIDX_W-1:0] wbck_rdidx,
  output logic               wbck_rdfpu,
  output logic [ITAG_W-1:0]  wbck_itag
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]        wdat;
    logic [RDIDX_W-1:0] rdidx;
    logic               rdfpu;
    logic [ITAG_W-1:0]  itag;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head, wr_ent;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          rr;
  logic          pop, push, has_room, blocked, gnt0, gnt1;

  assign wbck_valid = (cnt != '0);
  assign pop        = wbck_valid & wbck_ready;
  assign has_room   = (cnt < CW'(DEPTH)) | pop;
  assign blocked    = flush_req | ~has_room;

  // rr = 0 favours requester 0 when both contend
  assign gnt0 = ~blocked & r0_valid & (~r1_valid | ~rr);
  assign gnt1 = ~blocked & r1_valid & (~r0_valid |  rr);

  assign mv_i_valid = gnt0 | gnt1;
  assign mv_i_rs1   = gnt0 ? r0_rs1 : (gnt1 ? r1_rs1 : 32'h0);
  assign mv_o_ready = has_room & ~flush_req;
  assign r0_ready   = gnt0 & mv_i_ready;
  assign r1_ready   = gnt1 & mv_i_ready;
  assign push       = mv_o_valid & mv_o_ready;

  // Datapath is combinational, so the grant's sideband is still valid at push time
  always_comb begin
    wr_ent       = '0;
    wr_ent.wdat  = mv_o_wdat;
    wr_ent.rdidx = gnt1 ? r1_rdidx : r0_rdidx;
    wr_ent.itag  = gnt1 ? r1_itag  : r0_itag;
    wr_ent.rdfpu = gnt0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr     <= 1'b0;
    end else if (flush_req) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      cnt <= cnt + 1'b1;
      else if (pop & ~push) cnt <= cnt - 1'b1;
      if (push & r0_valid & r1_valid) rr <= gnt0;
    end
  end

  // Outputs are forced to zero while empty so stale entries never leak out
  assign head       = mem[rd_ptr];
  assign wbck_wdat  = wbck_valid ? head.wdat  : '0;
  assign wbck_rdidx = wbck_valid ? head.rdidx : '0;
  assign wbck_rdfpu = wbck_valid ? head.rdfpu : 1'b0;
  assign wbck_itag  = wbck_valid ? head.itag  : '0;
endmodule

// File: tb/tb_e203_exu_fpu_fmis_arb.sv
// Directed bench for the misc-move arbiter; the datapath is modelled as a pass-through.
module tb_e203_exu_fpu_fmis_arb;
  logic        clk, rst_n, flush_req;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_rs1, r1_rs1;
  logic [4:0]  r0_rdidx, r1_rdidx;
  logic [1:0]  r0_itag, r1_itag;
  logic        mv_i_valid, mv_i_ready, mv_o_valid, mv_o_ready, dp_rdy;
  logic [31:0] mv_i_rs1, mv_o_wdat;
  logic        wbck_valid, wbck_ready, wbck_rdfpu;
  logic [31:0] wbck_wdat;
  logic [4:0]  wbck_rdidx;
  logic [1:0]  wbck_itag;
  int n_chk = 0, n_fail = 0;

  assign mv_i_ready = dp_rdy;
  assign mv_o_valid = mv_i_valid & dp_rdy;
  assign mv_o_wdat  = mv_i_rs1;

  e203_exu_fpu_fmis_arb #(.DEPTH(2), .ITAG_W(2), .RDIDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_rs1(r0_rs1), .r0_rdidx(r0_rdidx), .r0_itag(r0_itag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_rs1(r1_rs1), .r1_rdidx(r1_rdidx), .r1_itag(r1_itag),
    .mv_i_valid(mv_i_valid), .mv_i_ready(mv_i_ready), .mv_i_rs1(mv_i_rs1),
    .mv_o_valid(mv_o_valid), .mv_o_ready(mv_o_ready), .mv_o_wdat(mv_o_wdat),
    .wbck_valid(wbck_valid), .wbck_ready(wbck_ready), .wbck_wdat(wbck_wdat),
    .wbck_rdidx(wbck_rdidx), .wbck_rdfpu(wbck_rdfpu), .wbck_itag(wbck_itag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; flush_req = 0; dp_rdy = 1; wbck_ready = 0;
    r0_valid = 0; r0_rs1 = 0; r0_rdidx = 0; r0_itag = 0;
    r1_valid = 0; r1_rs1 = 0; r1_rdidx = 0; r1_itag = 0;
    #3;
    chk("rst_wbck_valid", wbck_valid, 0);
    chk("rst_wbck_wdat", wbck_wdat, 0);
    chk("rst_wbck_rdidx", wbck_rdidx, 0);
    #9 rst_n = 1;
    tick();

    // single op
    wbck_ready = 1; r0_valid = 1; r0_rs1 = 32'h3F80_0000; r0_rdidx = 3; r0_itag = 1;
    #1;
    chk("single_r0_ready", r0_ready, 1);
    chk("single_no_bypass", wbck_valid, 0);
    tick();
    r0_valid = 0;
    #1;
    chk("single_wbck_valid", wbck_valid, 1);
    chk("single_wdat", wbck_wdat, 32'h3F80_0000);
    chk("single_rdidx", wbck_rdidx, 3);
    chk("single_rdfpu", wbck_rdfpu, 1);
    chk("single_itag", wbck_itag, 1);
    tick();
    chk("single_drained", wbck_valid, 0);

    // contention: grants alternate starting with r0
    for (int k = 0; k < 4; k++) begin
      r0_valid = 1; r1_valid = 1;
      r0_rs1 = 32'hA000_0000 + k; r1_rs1 = 32'hB000_0000 + k; r1_rdidx = 9; r1_itag = 2;
      #1;
      chk($sformatf("cont_r0_ready_%0d", k), r0_ready, (k % 2 == 0));
      chk($sformatf("cont_r1_ready_%0d", k), r1_ready, (k % 2 == 1));
      if (k > 0) chk($sformatf("cont_rdfpu_%0d", k - 1), wbck_rdfpu, ((k - 1) % 2 == 0));
      tick();
    end
    r0_valid = 0; r1_valid = 0;
    #1;
    chk("cont_rdfpu_3", wbck_rdfpu, 0);
    chk("cont_wdat_3", wbck_wdat, 32'hB000_0003);
    chk("cont_rdidx_3", wbck_rdidx, 9);
    tick();

    // backpressure: FIFO fills at 2
    wbck_ready = 0; r1_valid = 1; r1_rs1 = 32'hC1; r1_rdidx = 7; r1_itag = 2;
    #1; chk("bp_acc1", r1_ready, 1);
    tick();
    r1_rs1 = 32'hC2;
    #1; chk("bp_acc2", r1_ready, 1);
    tick();
    r1_rs1 = 32'hC3;
    #1;
    chk("bp_full_r1_ready", r1_ready, 0);
    chk("bp_full_mv_o_ready", mv_o_ready, 0);
    chk("bp_head", wbck_wdat, 32'hC1);
    tick();
    chk("bp_still_full", r1_ready, 0);
    wbck_ready = 1;
    #1; chk("bp_pop_push", r1_ready, 1);
    tick();
    wbck_ready = 0; r1_rs1 = 32'hC4;
    #1;
    chk("bp_count_2", r1_ready, 0);
    chk("bp_head2", wbck_wdat, 32'hC2);
    chk("bp_head2_rdfpu", wbck_rdfpu, 0);
    r1_valid = 0; wbck_ready = 1;
    tick();
    chk("bp_head3", wbck_wdat, 32'hC3);
    tick();
    chk("bp_drained", wbck_valid, 0);

    // datapath stall: no acceptance, rr unchanged (still favours r0)
    dp_rdy = 0; r0_valid = 1; r1_valid = 1; r0_rs1 = 32'hD0; r1_rs1 = 32'hD1;
    #1;
    chk("stall_r0_ready", r0_ready, 0);
    chk("stall_r1_ready", r1_ready, 0);
    chk("stall_mv_i_valid", mv_i_valid, 1);
    tick();
    chk("stall_no_push", wbck_valid, 0);
    dp_rdy = 1;
    #1; chk("stall_rr_kept", r0_ready, 1);
    tick();
    r0_valid = 0; r1_valid = 0;
    #1; chk("stall_rdfpu", wbck_rdfpu, 1);
    tick();

    // flush with 2 buffered entries; rr now favours r1 and must survive the flush
    wbck_ready = 0; r0_valid = 1; r0_rs1 = 32'hE1;
    tick();
    r0_rs1 = 32'hE2;
    tick();
    flush_req = 1; wbck_ready = 1; r0_rs1 = 32'hE3;
    #1;
    chk("flush_r0_ready", r0_ready, 0);
    chk("flush_mv_i_valid", mv_i_valid, 0);
    tick();
    flush_req = 0;
    #1;
    chk("flush_empty", wbck_valid, 0);
    chk("flush_new_acc", r0_ready, 1);
    tick();
    chk("flush_new_wdat", wbck_wdat, 32'hE3);
    r1_valid = 1; r1_rs1 = 32'hF1;
    #1;
    chk("flush_rr_r1", r1_ready, 1);
    chk("flush_rr_r0", r0_ready, 0);
    tick();
    r0_valid = 0; r1_valid = 0;
    #1;
    chk("flush_after_wdat", wbck_wdat, 32'hF1);
    chk("flush_after_rdfpu", wbck_rdfpu, 0);

    // async reset mid-stream with one entry buffered
    wbck_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("areset_valid", wbck_valid, 0);
    chk("areset_wdat", wbck_wdat, 0);
    #3 rst_n = 1;
    tick();
    chk("areset_after", wbck_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
